fir_xifu_wb: RTL and testbench

FIR_XIFU_WB -- requirements
Module: fir_xifu_wb

---
 rtl/fir_xifu_pkg.sv | 61 ++++++
 rtl/fir_xifu_wb.sv | 157 +++++++++++++++
 tb/tb_fir_xifu_wb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_xifu_pkg.sv
// -----------------------------------------------------------------------------
// fir_xifu_pkg
// Shared types for the FIR XIFU pipeline.
// Contents:
//   - instruction encodings (INSTR_*), INSTR_NONE marks a bubble
//   - WB stage FSM states (wb_state_e)
//   - EX/WB register (ex2wb_t), forwarding bus (wb_fwd_t)
//   - WB outputs to core GPR (wb2core_t) and to XIFU regfile (wb2regfile_t)
//   - is_mem_instr() helper for the load/store class
// -----------------------------------------------------------------------------
package fir_xifu_pkg;

   localparam int unsigned XID_W = 4;

   typedef enum logic [1:0] {
      INSTR_NONE     = 2'd0,
      INSTR_XFIRDOTP = 2'd1,
      INSTR_XFIRLW   = 2'd2,
      INSTR_XFIRSW   = 2'd3
   } instr_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      RESULT   = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic [31:0]      result;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      instr_e           instr;
      logic [XID_W-1:0] id;
   } ex2wb_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] result;
   } wb_fwd_t;

   typedef struct packed {
      logic [XID_W-1:0] id;
      logic             we;
      logic [4:0]       rd;
      logic [31:0]      data;
   } wb2core_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } wb2regfile_t;

   // Load/store instructions wait for the core LSU and write back an address.
   function automatic logic is_mem_instr(input instr_e instr);
      return (instr == INSTR_XFIRLW) || (instr == INSTR_XFIRSW);
   endfunction

endpackage

// File: rtl/fir_xifu_wb.sv
// -----------------------------------------------------------------------------
// fir_xifu_wb
// Write-back stage of the FIR XIFU. Holds the instruction in ex2wb_i until the
// core accepts the XIF result, waits for the LSU response of load/store ops,
// and writes the XIFU register file / forwards to EX in the handshake cycle.
// Ports:
//   clk_i, rst_i (sync, active-high), clear_i (sync flush)
//   ex2wb_i                 EX/WB register, instr == INSTR_NONE is a bubble
//   mem_result_*_i          LSU response (valid, id, load data)
//   result_valid_o/ready_i  XIF result handshake, result_o payload
//   wb2regfile_o            XIFU regfile write port
//   wb_fwd_o                forwarding of the post-incremented address to EX
//   ready_o                 EX/WB register may advance this cycle
// -----------------------------------------------------------------------------
module fir_xifu_wb
   import fir_xifu_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  ex2wb_t                ex2wb_i,
   input  logic                  mem_result_valid_i,
   input  logic [X_ID_WIDTH-1:0] mem_result_id_i,
   input  logic [31:0]           mem_result_rdata_i,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output wb2core_t              result_o,
   output wb2regfile_t           wb2regfile_o,
   output wb_fwd_t               wb_fwd_o,
   output logic                  ready_o
);

   wb_state_e   state_q, state_d;
   logic [31:0] rdata_q, rdata_d;

   logic active_s;
   logic is_mem_s;
   logic mem_match_s;
   logic unused_rs2_s;

   // Outputs are suppressed in reset and in a flush cycle.
   assign active_s     = ~rst_i & ~clear_i;
   assign is_mem_s     = is_mem_instr(ex2wb_i.instr);
   assign mem_match_s  = mem_result_valid_i &
                         (mem_result_id_i == X_ID_WIDTH'(ex2wb_i.id));
   assign unused_rs2_s = ^ex2wb_i.rs2;

   // State and load-data capture registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic; clear_i overrides every transition.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      if (clear_i) begin
         state_d = IDLE;
         rdata_d = 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               case (ex2wb_i.instr)
                  INSTR_XFIRDOTP: state_d = RESULT;
                  INSTR_XFIRLW:   state_d = WAIT_MEM;
                  INSTR_XFIRSW:   state_d = WAIT_MEM;
                  default:        state_d = IDLE;
               endcase
            end
            WAIT_MEM: begin
               // Responses for other ids belong to other instructions.
               if (mem_match_s) begin
                  rdata_d = mem_result_rdata_i;
                  state_d = RESULT;
               end else begin
                  state_d = WAIT_MEM;
               end
            end
            RESULT: begin
               if (result_ready_i) begin
                  state_d = IDLE;
               end else begin
                  state_d = RESULT;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output muxes: result offer, handshake-cycle writes, forwarding, ready.
   always_comb begin
      result_valid_o = 1'b0;
      ready_o        = 1'b0;
      result_o       = '0;
      wb2regfile_o   = '0;
      wb_fwd_o       = '0;
      if (active_s) begin
         if (state_q == RESULT) begin
            result_valid_o = 1'b1;
            result_o.id    = ex2wb_i.id;
            // result_o depends only on the held EX/WB register, so it is
            // stable while the core stalls.
            if (is_mem_s) begin
               result_o.we   = 1'b1;
               result_o.rd   = ex2wb_i.rs1;
               result_o.data = ex2wb_i.result;
            end else begin
               result_o.we   = 1'b0;
               result_o.rd   = 5'd0;
               result_o.data = 32'd0;
            end
            if (result_ready_i) begin
               ready_o = 1'b1;
               case (ex2wb_i.instr)
                  INSTR_XFIRLW: begin
                     wb2regfile_o.we    = 1'b1;
                     wb2regfile_o.rd    = ex2wb_i.rd;
                     wb2regfile_o.wdata = rdata_q;
                  end
                  INSTR_XFIRDOTP: begin
                     wb2regfile_o.we    = 1'b1;
                     wb2regfile_o.rd    = ex2wb_i.rd;
                     wb2regfile_o.wdata = ex2wb_i.result;
                  end
                  default: wb2regfile_o = '0;
               endcase
               if (is_mem_s) begin
                  wb_fwd_o.we     = 1'b1;
                  wb_fwd_o.rd     = ex2wb_i.rs1;
                  wb_fwd_o.result = ex2wb_i.result;
               end else begin
                  wb_fwd_o = '0;
               end
            end else begin
               ready_o = 1'b0;
            end
         end else if (state_q == IDLE) begin
            // Bubbles drain immediately; real instructions wait for handshake.
            ready_o = (ex2wb_i.instr == INSTR_NONE);
         end else begin
            ready_o = 1'b0;
         end
      end else begin
         ready_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_xifu_wb.sv
module tb_fir_xifu_wb;
   import fir_xifu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        clear_i;
   ex2wb_t      ex2wb_i;
   logic        mem_result_valid_i;
   logic [3:0]  mem_result_id_i;
   logic [31:0] mem_result_rdata_i;
   logic        result_valid_o;
   logic        result_ready_i;
   wb2core_t    result_o;
   wb2regfile_t wb2regfile_o;
   wb_fwd_t     wb_fwd_o;
   logic        ready_o;

   fir_xifu_wb #(.X_ID_WIDTH(4)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .clear_i            (clear_i),
      .ex2wb_i            (ex2wb_i),
      .mem_result_valid_i (mem_result_valid_i),
      .mem_result_id_i    (mem_result_id_i),
      .mem_result_rdata_i (mem_result_rdata_i),
      .result_valid_o     (result_valid_o),
      .result_ready_i     (result_ready_i),
      .result_o           (result_o),
      .wb2regfile_o       (wb2regfile_o),
      .wb_fwd_o           (wb_fwd_o),
      .ready_o            (ready_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      wb2core_t    core;
      wb2regfile_t rf;
      wb_fwd_t     fwd;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   rf_writes = 0;
   int   results   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input instr_e ins, input logic [3:0] id, input logic [4:0] rs1,
                        input logic [4:0] rd, input logic [31:0] res);
      ex2wb_i.instr  = ins;
      ex2wb_i.id     = id;
      ex2wb_i.rs1    = rs1;
      ex2wb_i.rs2    = 5'd0;
      ex2wb_i.rd     = rd;
      ex2wb_i.result = res;
   endtask

   task automatic push(input wb2core_t c, input wb2regfile_t r, input wb_fwd_t f);
      exp_t e;
      e.core = c;
      e.rf   = r;
      e.fwd  = f;
      sb_q.push_back(e);
   endtask

   // Scoreboard: every accepted result is compared with the oldest expectation.
   always @(negedge clk_i) begin
      exp_t e;
      if (wb2regfile_o.we) rf_writes++;
      if (result_valid_o && result_ready_i) begin
         results++;
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("mon_core", 64'(result_o), 64'(e.core));
            chk("mon_rf",   64'(wb2regfile_o), 64'(e.rf));
            chk("mon_fwd",  64'(wb_fwd_o), 64'(e.fwd));
         end
      end
   end

   int r0, s0;

   initial begin
      rst_i              = 1'b1;
      clear_i            = 1'b0;
      mem_result_valid_i = 1'b0;
      mem_result_id_i    = 4'd0;
      mem_result_rdata_i = 32'd0;
      result_ready_i     = 1'b1;
      drive(INSTR_XFIRDOTP, 4'd1, 5'd1, 5'd1, 32'h1);
      repeat (2) cyc();
      @(negedge clk_i);
      chk("rst_valid", 64'(result_valid_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_rf_we", 64'(wb2regfile_o.we), 64'd0);
      chk("rst_state", 64'(dut.state_q), 64'(IDLE));
      cyc();
      rst_i = 1'b0;
      drive(INSTR_NONE, 4'd0, 5'd0, 5'd0, 32'd0);
      @(negedge clk_i);
      chk("idle_bubble_ready", 64'(ready_o), 64'd1);

      // Stray LSU response in IDLE is ignored.
      cyc();
      mem_result_valid_i = 1'b1;
      mem_result_id_i    = 4'd0;
      cyc();
      mem_result_valid_i = 1'b0;
      @(negedge clk_i);
      chk("stray_mem_state", 64'(dut.state_q), 64'(IDLE));

      // DOTP: valid at T+1, regfile write, ready_o in the same cycle.
      cyc();
      drive(INSTR_XFIRDOTP, 4'd3, 5'd0, 5'd5, 32'h0000_0100);
      push('{id: 4'd3, we: 1'b0, rd: 5'd0, data: 32'd0},
           '{we: 1'b1, rd: 5'd5, wdata: 32'h100}, '0);
      @(negedge clk_i);
      chk("dotp_T_valid", 64'(result_valid_o), 64'd0);
      chk("dotp_T_ready", 64'(ready_o), 64'd0);
      cyc();
      @(negedge clk_i);
      chk("dotp_T1_valid", 64'(result_valid_o), 64'd1);
      chk("dotp_T1_ready", 64'(ready_o), 64'd1);
      cyc();

      // LW: response at T+3, result at T+4.
      drive(INSTR_XFIRLW, 4'd2, 5'd10, 5'd7, 32'h1004);
      push('{id: 4'd2, we: 1'b1, rd: 5'd10, data: 32'h1004},
           '{we: 1'b1, rd: 5'd7, wdata: 32'hDEAD_BEEF},
           '{we: 1'b1, rd: 5'd10, result: 32'h1004});
      @(negedge clk_i);
      chk("lw_T_valid", 64'(result_valid_o), 64'd0);
      repeat (3) cyc();
      mem_result_valid_i = 1'b1;
      mem_result_id_i    = 4'd2;
      mem_result_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      chk("lw_resp_valid", 64'(result_valid_o), 64'd0);
      chk("lw_resp_ready", 64'(ready_o), 64'd0);
      cyc();
      mem_result_valid_i = 1'b0;
      @(negedge clk_i);
      chk("lw_T4_valid", 64'(result_valid_o), 64'd1);
      cyc();

      // SW: non-matching response first, no XIFU regfile write.
      drive(INSTR_XFIRSW, 4'd1, 5'd3, 5'd4, 32'h2000);
      push('{id: 4'd1, we: 1'b1, rd: 5'd3, data: 32'h2000}, '0,
           '{we: 1'b1, rd: 5'd3, result: 32'h2000});
      repeat (2) cyc();
      mem_result_valid_i = 1'b1;
      mem_result_id_i    = 4'd0;
      mem_result_rdata_i = 32'h1111_1111;
      @(negedge clk_i);
      chk("sw_wrongid_valid", 64'(result_valid_o), 64'd0);
      cyc();
      mem_result_id_i = 4'd1;
      @(negedge clk_i);
      chk("sw_match_valid", 64'(result_valid_o), 64'd0);
      cyc();
      mem_result_valid_i = 1'b0;
      @(negedge clk_i);
      chk("sw_valid", 64'(result_valid_o), 64'd1);
      chk("sw_rf_we", 64'(wb2regfile_o.we), 64'd0);
      cyc();

      // Backpressure: 3 stalled cycles in RESULT, single write on acceptance.
      r0 = rf_writes;
      drive(INSTR_XFIRDOTP, 4'd4, 5'd0, 5'd9, 32'h55);
      result_ready_i = 1'b0;
      push('{id: 4'd4, we: 1'b0, rd: 5'd0, data: 32'd0},
           '{we: 1'b1, rd: 5'd9, wdata: 32'h55}, '0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("bp_valid", 64'(result_valid_o), 64'd1);
         chk("bp_ready", 64'(ready_o), 64'd0);
         chk("bp_core_stable", 64'(result_o), 64'({4'd4, 1'b0, 5'd0, 32'd0}));
         chk("bp_rf_we", 64'(wb2regfile_o.we), 64'd0);
         cyc();
      end
      result_ready_i = 1'b1;
      @(negedge clk_i);
      chk("bp_accept_ready", 64'(ready_o), 64'd1);
      cyc();
      drive(INSTR_NONE, 4'd0, 5'd0, 5'd0, 32'd0);
      chk("bp_single_write", 64'(rf_writes), 64'(r0 + 1));

      // Reset in WAIT_MEM drops the instruction.
      r0 = rf_writes;
      s0 = results;
      drive(INSTR_XFIRLW, 4'd5, 5'd1, 5'd2, 32'h40);
      cyc();
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rstw_ready", 64'(ready_o), 64'd0);
      chk("rstw_valid", 64'(result_valid_o), 64'd0);
      cyc();
      rst_i = 1'b0;
      drive(INSTR_NONE, 4'd0, 5'd0, 5'd0, 32'd0);
      @(negedge clk_i);
      chk("rstw_state", 64'(dut.state_q), 64'(IDLE));
      chk("rstw_rdata", 64'(dut.rdata_q), 64'd0);

      // Clear in RESULT with captured data: outputs suppressed, rdata zeroed.
      cyc();
      result_ready_i = 1'b0;
      drive(INSTR_XFIRLW, 4'd6, 5'd2, 5'd3, 32'h80);
      cyc();
      mem_result_valid_i = 1'b1;
      mem_result_id_i    = 4'd6;
      mem_result_rdata_i = 32'hCAFE_F00D;
      cyc();
      mem_result_valid_i = 1'b0;
      @(negedge clk_i);
      chk("clr_pre_valid", 64'(result_valid_o), 64'd1);
      chk("clr_pre_rdata", 64'(dut.rdata_q), 64'hCAFE_F00D);
      cyc();
      clear_i        = 1'b1;
      result_ready_i = 1'b1;
      @(negedge clk_i);
      chk("clr_valid", 64'(result_valid_o), 64'd0);
      chk("clr_ready", 64'(ready_o), 64'd0);
      chk("clr_rf_we", 64'(wb2regfile_o.we), 64'd0);
      cyc();
      clear_i = 1'b0;
      drive(INSTR_NONE, 4'd0, 5'd0, 5'd0, 32'd0);
      @(negedge clk_i);
      chk("clr_state", 64'(dut.state_q), 64'(IDLE));
      chk("clr_rdata", 64'(dut.rdata_q), 64'd0);

      // Clear in WAIT_MEM.
      cyc();
      drive(INSTR_XFIRSW, 4'd7, 5'd4, 5'd5, 32'hC0);
      cyc();
      clear_i = 1'b1;
      @(negedge clk_i);
      chk("clrw_ready", 64'(ready_o), 64'd0);
      cyc();
      clear_i = 1'b0;
      drive(INSTR_NONE, 4'd0, 5'd0, 5'd0, 32'd0);
      @(negedge clk_i);
      chk("clrw_state", 64'(dut.state_q), 64'(IDLE));
      repeat (2) cyc();
      chk("drop_no_write", 64'(rf_writes), 64'(r0));
      chk("drop_no_result", 64'(results), 64'(s0));
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
